port_output_x8: RTL and testbench
=================================

# port_output_x8

Output side of the PIC16F84 I/O port model, and the write-path counterpart of the TRIS-gated input path. Holds the 8-bit port data latch and TRIS register, accepts byte and bit-level writes from the CPU core, commits them on the Q4 phase of the instruction cycle, and drives pin value and output-enable per bit. Sits between the core's register-file write port and the QSPICE pin models. Its internal Q1–Q4 phase sequencer is exported for the other port blocks.

## Interface
Parameters:
- RESET_LATCH, 8'h00, port data latch value after reset
- RESET_TRIS, 8'hFF, TRIS value after reset (all inputs)

Ports:
- clk  input  1  system clock; one clk = one Q phase
- rst  input  1  asynchronous, active-high reset
- wr_req  input  1  write request, sampled every clk
- wr_sel  input  1  target: 0 = PORT latch, 1 = TRIS
- wr_op  input  2  00 byte write, 01 bit set, 10 bit clear, 11 bit toggle
- wr_bit  input  3  bit index for bit ops
- wr_data  input  8  byte-write data
- wr_busy  output  1  a write is pending
- wr_ack  output  1  one-cycle pulse: a write committed
- q_phase  output  2  current phase, 0..3 = Q1..Q4
- port_latch  output  8  data latch contents
- tris_reg  output  8  TRIS contents; 1 = input
- pin_out  output  8  value driven onto pins
- pin_oe  output  8  per-bit output enable

## Operation
- Phase counter: 2-bit, increments every clk, wraps from 3 to 0.
- Write capture: wr_req=1 while wr_busy=0 latches sel/op/bit/data into a pending slot and sets wr_busy.
- If the capture cycle is itself Q4 (q_phase=3), the write commits on that edge and no pending state is entered.
- Commit: on the clk edge ending a Q4 cycle with a write pending, apply the op to the selected register, clear wr_busy, and pulse wr_ack=1 for the following cycle.
- wr_req while wr_busy=1 is ignored and dropped. The requester must hold off until wr_ack.
- Ops:
  - Byte write replaces all 8 bits.
  - Set, clear, and toggle modify only bit wr_bit. They are read-modify-write on the current register value at commit time, not at capture time.
- Drive: pin_oe[i] = ~tris_reg[i]; pin_out[i] = port_latch[i].
- The latch is writable while a bit is an input. The new value appears on the pin when TRIS later clears.
- Reset, asynchronous, including mid-request:
  - q_phase=0, port_latch=RESET_LATCH, tris_reg=RESET_TRIS.
  - wr_busy=0, wr_ack=0.
  - The pending write is discarded.

## Timing
- Write latency, wr_req to register update:
  - Captured in Q1: 4 clks.
  - Captured in Q2: 3 clks.
  - Captured in Q3: 2 clks.
  - Captured in Q4: 1 clk.
- wr_ack is asserted during the cycle after the commit edge. That cycle is always Q1.
- All outputs are registered or pure functions of registers; there is no combinational path from wr_* to any output.
- wr_busy rises the edge after capture and falls on the commit edge.

## Configuration
- PORTA_RA4_OD_EN defined: bit 4 is open-drain.
  - pin_out[4]=0 always.
  - pin_oe[4] = ~tris_reg[4] & ~port_latch[4]. The pin is released, never driven high.
- Not defined: bit 4 behaves push-pull like all other bits.

## Structure
- Shared package port_pkg:
  - Op encodings OP_BYTE, OP_SET, OP_CLR, OP_TGL.
  - Phase constants Q1..Q4.
  - Select constants SEL_PORT, SEL_TRIS.
- One sub-module, q_phase_gen: the 2-bit phase counter with async reset. It is reusable by the input-side blocks.
- Pending slot, op ALU, and drive logic stay in the top module.

## Test plan
- Reset: assert rst mid-cycle -> q_phase=0, tris_reg=FF, port_latch=00, pin_oe=00, wr_busy=0 immediately, without waiting for clk.
- Byte write in Q1: PORT data A5 -> wr_busy for 3 clks, port_latch=A5 after Q4 edge, wr_ack in next Q1. Then TRIS 0F -> pin_oe=F0, pin_out=A5.
- Write in Q4: TRIS byte 00 presented at q_phase=3 -> tris_reg=00 on that edge, wr_busy never set, wr_ack next cycle.
- Bit ops: latch 00; set bit 7 -> 80; toggle bit 0 -> 81; clear bit 7 -> 01. Each acked once.
- Busy drop: second wr_req (data FF) issued while first (data 3C) is pending -> latch=3C, exactly one wr_ack.
- RA4 open drain with PORTA_RA4_OD_EN: TRIS=00, latch=10 -> pin_oe[4]=0; latch=00 -> pin_oe[4]=1, pin_out[4]=0. Without the macro, latch=10 -> pin_oe[4]=1, pin_out[4]=1.

Source files
------------

// File: rtl/port_pkg.sv
// Shared encodings for the PIC16F84 port model blocks: write ops, Q phases, register selects.
// Also holds the op ALU used at commit time.
package port_pkg;

  typedef enum logic [1:0] {
    OP_BYTE = 2'b00,
    OP_SET  = 2'b01,
    OP_CLR  = 2'b10,
    OP_TGL  = 2'b11
  } wr_op_e;

  localparam logic [1:0] Q1 = 2'd0;
  localparam logic [1:0] Q2 = 2'd1;
  localparam logic [1:0] Q3 = 2'd2;
  localparam logic [1:0] Q4 = 2'd3;

  localparam logic SEL_PORT = 1'b0;
  localparam logic SEL_TRIS = 1'b1;

  typedef struct packed {
    logic       sel;
    wr_op_e     op;
    logic [2:0] bit_idx;
    logic [7:0] data;
  } wr_slot_t;

  // Bit ops read the register as it stands on the commit edge.
  function automatic logic [7:0] apply_op(input logic [7:0] cur, input wr_slot_t w);
    logic [7:0] mask;
    logic [7:0] res;
    mask = 8'h01 << w.bit_idx;
    res  = cur;
    case (w.op)
      OP_BYTE: res = w.data;
      OP_SET:  res = cur | mask;
      OP_CLR:  res = cur & ~mask;
      OP_TGL:  res = cur ^ mask;
      default: res = cur;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/q_phase_gen.sv
// Free-running Q1..Q4 instruction-cycle phase counter; one clk per phase, back to Q1 on reset.
module q_phase_gen
  import port_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  output logic [1:0] q_phase_o
);

  logic [1:0] phase_q;
  logic [1:0] phase_d;

  assign phase_d   = phase_q + 2'd1;
  assign q_phase_o = phase_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) phase_q <= Q1;
    else       phase_q <= phase_d;
  end

endmodule

// File: rtl/port_output_x8.sv
// Port data latch + TRIS write path: single pending write slot committed on the Q4 edge, ack in next Q1.
// Optional PORTA_RA4_OD_EN makes bit 4 open-drain; requests arriving while busy are dropped.
module port_output_x8
  import port_pkg::*;
#(
  parameter logic [7:0] RESET_LATCH = 8'h00,
  parameter logic [7:0] RESET_TRIS  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_req,
  input  logic       wr_sel,
  input  logic [1:0] wr_op,
  input  logic [2:0] wr_bit,
  input  logic [7:0] wr_data,
  output logic       wr_busy,
  output logic       wr_ack,
  output logic [1:0] q_phase,
  output logic [7:0] port_latch,
  output logic [7:0] tris_reg,
  output logic [7:0] pin_out,
  output logic [7:0] pin_oe
);

  logic [1:0] phase;
  wr_slot_t   req_in;
  wr_slot_t   pend_q, pend_d;
  wr_slot_t   cmt;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic [7:0] latch_q, latch_d;
  logic [7:0] tris_q, tris_d;
  logic       do_cmt;

  q_phase_gen u_phase (
    .clk_i     (clk),
    .rst_i     (rst),
    .q_phase_o (phase)
  );

  assign req_in = '{sel: wr_sel, op: wr_op_e'(wr_op), bit_idx: wr_bit, data: wr_data};
  // A request captured in Q4 bypasses the slot and commits on the same edge.
  assign cmt    = busy_q ? pend_q : req_in;
  assign do_cmt = (phase == Q4) && (busy_q || wr_req);

  always_comb begin
    pend_d  = pend_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    latch_d = latch_q;
    tris_d  = tris_q;
    if (!busy_q && wr_req && (phase != Q4)) begin
      pend_d = req_in;
      busy_d = 1'b1;
    end
    if (do_cmt) begin
      busy_d = 1'b0;
      ack_d  = 1'b1;
      if (cmt.sel == SEL_TRIS) tris_d  = apply_op(tris_q, cmt);
      else                     latch_d = apply_op(latch_q, cmt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      latch_q <= RESET_LATCH;
      tris_q  <= RESET_TRIS;
    end else begin
      pend_q  <= pend_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      latch_q <= latch_d;
      tris_q  <= tris_d;
    end
  end

  always_comb begin
    pin_oe  = ~tris_q;
    pin_out = latch_q;
`ifdef PORTA_RA4_OD_EN
    // RA4 can only pull low; a latched 1 releases the pin instead of driving it.
    pin_out[4] = 1'b0;
    pin_oe[4]  = ~tris_q[4] & ~latch_q[4];
`endif
  end

  assign wr_busy    = busy_q;
  assign wr_ack     = ack_q;
  assign q_phase    = phase;
  assign port_latch = latch_q;
  assign tris_reg   = tris_q;

endmodule

// File: tb/tb_port_output_x8.sv
// Directed bench for port_output_x8: reset, phase-dependent write latency, bit ops, busy drop, RA4 drive.
module tb_port_output_x8;
  import port_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_req = 1'b0;
  logic       wr_sel = 1'b0;
  logic [1:0] wr_op = 2'b00;
  logic [2:0] wr_bit = 3'd0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_busy, wr_ack;
  logic [1:0] q_phase;
  logic [7:0] port_latch, tris_reg, pin_out, pin_oe;

  int total = 0;
  int bad   = 0;

  port_output_x8 dut (
    .clk(clk), .rst(rst), .wr_req(wr_req), .wr_sel(wr_sel), .wr_op(wr_op),
    .wr_bit(wr_bit), .wr_data(wr_data), .wr_busy(wr_busy), .wr_ack(wr_ack),
    .q_phase(q_phase), .port_latch(port_latch), .tris_reg(tris_reg),
    .pin_out(pin_out), .pin_oe(pin_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       sel;
    logic [1:0] op;
    logic [2:0] bitx;
    logic [7:0] data;
    logic [1:0] ph;
    logic [7:0] e_latch;
    logic [7:0] e_tris;
    logic [7:0] e_oe;
    logic [7:0] e_out;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input logic [1:0] p);
    int n = 0;
    while (q_phase !== p && n < 8) begin
      step();
      n++;
    end
    if (q_phase !== p) chk("phase_wait_timeout", {30'd0, q_phase}, {30'd0, p});
  endtask

  // Presents one request for a single cycle in phase ph, returns edges until wr_ack seen.
  task automatic issue(input logic sel, input logic [1:0] op, input logic [2:0] bitx,
                       input logic [7:0] data, input logic [1:0] ph,
                       output int lat, output logic first_busy);
    wait_phase(ph);
    wr_sel  = sel;
    wr_op   = op;
    wr_bit  = bitx;
    wr_data = data;
    wr_req  = 1'b1;
    lat = 0;
    first_busy = 1'b0;
    do begin
      step();
      wr_req = 1'b0;
      lat++;
      if (lat == 1) first_busy = wr_busy;
    end while (wr_ack !== 1'b1 && lat < 12);
  endtask

  initial begin
    int lat;
    logic fb;
    int acks;

    tbl[0]  = '{SEL_TRIS, OP_BYTE, 3'd0, 8'h0F, 2'd1, 8'hA5, 8'h0F, 8'hF0, 8'hA5};
    tbl[1]  = '{SEL_PORT, OP_BYTE, 3'd0, 8'h00, 2'd2, 8'h00, 8'h0F, 8'hF0, 8'h00};
    tbl[2]  = '{SEL_PORT, OP_SET,  3'd7, 8'h00, 2'd3, 8'h80, 8'h0F, 8'hF0, 8'h80};
    tbl[3]  = '{SEL_PORT, OP_TGL,  3'd0, 8'h00, 2'd0, 8'h81, 8'h0F, 8'hF0, 8'h81};
    tbl[4]  = '{SEL_PORT, OP_CLR,  3'd7, 8'hFF, 2'd1, 8'h01, 8'h0F, 8'hF0, 8'h01};
    tbl[5]  = '{SEL_TRIS, OP_SET,  3'd0, 8'h00, 2'd2, 8'h01, 8'h0F, 8'hF0, 8'h01};
    tbl[6]  = '{SEL_TRIS, OP_CLR,  3'd3, 8'h00, 2'd3, 8'h01, 8'h07, 8'hF8, 8'h01};
    tbl[7]  = '{SEL_TRIS, OP_TGL,  3'd7, 8'h00, 2'd0, 8'h01, 8'h87, 8'h78, 8'h01};
    tbl[8]  = '{SEL_TRIS, OP_BYTE, 3'd0, 8'hFF, 2'd1, 8'h01, 8'hFF, 8'h00, 8'h01};
`ifdef PORTA_RA4_OD_EN
    tbl[9]  = '{SEL_PORT, OP_BYTE, 3'd0, 8'h5A, 2'd2, 8'h5A, 8'hFF, 8'h00, 8'h4A};
    tbl[10] = '{SEL_TRIS, OP_BYTE, 3'd0, 8'h00, 2'd3, 8'h5A, 8'h00, 8'hEF, 8'h4A};
    tbl[11] = '{SEL_PORT, OP_BYTE, 3'd0, 8'h10, 2'd0, 8'h10, 8'h00, 8'hEF, 8'h00};
`else
    tbl[9]  = '{SEL_PORT, OP_BYTE, 3'd0, 8'h5A, 2'd2, 8'h5A, 8'hFF, 8'h00, 8'h5A};
    tbl[10] = '{SEL_TRIS, OP_BYTE, 3'd0, 8'h00, 2'd3, 8'h5A, 8'h00, 8'hFF, 8'h5A};
    tbl[11] = '{SEL_PORT, OP_BYTE, 3'd0, 8'h10, 2'd0, 8'h10, 8'h00, 8'hFF, 8'h10};
`endif
    tbl[12] = '{SEL_PORT, OP_BYTE, 3'd0, 8'h00, 2'd1, 8'h00, 8'h00, 8'hFF, 8'h00};

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("rst_phase", {30'd0, q_phase}, 32'd0);
    chk("rst_tris", {24'd0, tris_reg}, 32'hFF);
    chk("rst_latch", {24'd0, port_latch}, 32'h00);
    chk("rst_oe", {24'd0, pin_oe}, 32'h00);
    chk("rst_busy", {31'd0, wr_busy}, 32'd0);
    chk("rst_ack", {31'd0, wr_ack}, 32'd0);
    step();
    step();
    rst = 1'b0;

    // Byte write captured in Q1: busy for Q2..Q4, commit on the Q4 edge.
    wait_phase(2'd0);
    wr_sel = SEL_PORT; wr_op = OP_BYTE; wr_bit = 3'd0; wr_data = 8'hA5; wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    chk("q1_busy_c1", {31'd0, wr_busy}, 32'd1);
    step();
    chk("q1_busy_c2", {31'd0, wr_busy}, 32'd1);
    step();
    chk("q1_busy_c3", {31'd0, wr_busy}, 32'd1);
    chk("q1_latch_pre", {24'd0, port_latch}, 32'h00);
    step();
    chk("q1_latch", {24'd0, port_latch}, 32'hA5);
    chk("q1_busy_done", {31'd0, wr_busy}, 32'd0);
    chk("q1_ack", {31'd0, wr_ack}, 32'd1);
    chk("q1_ack_phase", {30'd0, q_phase}, 32'd0);
    step();
    chk("q1_ack_drop", {31'd0, wr_ack}, 32'd0);

    for (int i = 0; i < 13; i++) begin
      issue(tbl[i].sel, tbl[i].op, tbl[i].bitx, tbl[i].data, tbl[i].ph, lat, fb);
      chk($sformatf("v%0d_ack", i), {31'd0, wr_ack}, 32'd1);
      chk($sformatf("v%0d_latency", i), lat, 32'(4 - int'(tbl[i].ph)));
      chk($sformatf("v%0d_busy", i), {31'd0, fb}, {31'd0, (tbl[i].ph != 2'd3)});
      chk($sformatf("v%0d_ack_phase", i), {30'd0, q_phase}, 32'd0);
      chk($sformatf("v%0d_latch", i), {24'd0, port_latch}, {24'd0, tbl[i].e_latch});
      chk($sformatf("v%0d_tris", i), {24'd0, tris_reg}, {24'd0, tbl[i].e_tris});
      chk($sformatf("v%0d_oe", i), {24'd0, pin_oe}, {24'd0, tbl[i].e_oe});
      chk($sformatf("v%0d_out", i), {24'd0, pin_out}, {24'd0, tbl[i].e_out});
      step();
      chk($sformatf("v%0d_single_ack", i), {31'd0, wr_ack}, 32'd0);
    end

    // A second request while busy is dropped.
    wait_phase(2'd0);
    wr_sel = SEL_PORT; wr_op = OP_BYTE; wr_data = 8'h3C; wr_req = 1'b1;
    step();
    wr_data = 8'hFF;
    step();
    wr_req = 1'b0;
    acks = 0;
    for (int c = 0; c < 10; c++) begin
      if (wr_ack === 1'b1) acks++;
      step();
    end
    chk("drop_acks", acks, 32'd1);
    chk("drop_latch", {24'd0, port_latch}, 32'h3C);

    // Reset mid-request discards the pending write.
    wait_phase(2'd0);
    wr_sel = SEL_PORT; wr_op = OP_BYTE; wr_data = 8'h77; wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, wr_busy}, 32'd0);
    chk("mid_rst_phase", {30'd0, q_phase}, 32'd0);
    chk("mid_rst_latch", {24'd0, port_latch}, 32'h00);
    chk("mid_rst_tris", {24'd0, tris_reg}, 32'hFF);
    chk("mid_rst_oe", {24'd0, pin_oe}, 32'h00);
    step();
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      if (wr_ack === 1'b1) acks++;
      step();
    end
    chk("mid_rst_no_ack", acks, 32'd0);
    chk("mid_rst_latch_kept", {24'd0, port_latch}, 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
